// File: rtl/red_iterativa_pkg.sv
// red_iterativa_pkg: comparison-state encoding shared by the cell and the top level
package red_iterativa_pkg;
    localparam logic [1:0] EQ = 2'b00;
    localparam logic [1:0] AG = 2'b10;
    localparam logic [1:0] BG = 2'b01;
    localparam int K_DEF = 4;
endpackage

// File: rtl/celda.sv
// celda: one MSB-first comparison cell; a decided state passes through, an equal state is resolved by (a, b)
module celda
    import red_iterativa_pkg::*;
(
    input  logic m_in,
    input  logic n_in,
    input  logic a,
    input  logic b,
    output logic m_out,
    output logic n_out
);
    logic [1:0] st_in;
    logic [1:0] st_out;
    always_comb begin
        st_in  = {m_in, n_in};
        st_out = (st_in == EQ) ? {a & ~b, ~a & b} :
                 (st_in == 2'b11) ? EQ : st_in;
    end
    assign {m_out, n_out} = st_out;
endmodule

// File: rtl/red_iterativa.sv
// red_iterativa: K-bit unsigned magnitude comparator built from a chain of cells, per-stage states and A>B verdict registered
module red_iterativa
    import red_iterativa_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic [K-1:0] M,
    output logic [K-1:0] N,
    output logic         Z
);
    logic         m_c [K];
    logic         n_c [K];
    logic [K-1:0] m_d, m_q, n_d, n_q;
    logic         z_d, z_q;
    for (genvar i = 0; i < K; i++) begin : g_cell
        if (i == K - 1) begin : g_top
            celda u_celda (.m_in(EQ[1]), .n_in(EQ[0]), .a(A[i]), .b(B[i]),
                           .m_out(m_c[i]), .n_out(n_c[i]));
        end else begin : g_rest
            celda u_celda (.m_in(m_c[i+1]), .n_in(n_c[i+1]), .a(A[i]), .b(B[i]),
                           .m_out(m_c[i]), .n_out(n_c[i]));
        end
    end
    always_comb begin
        for (int j = 0; j < K; j++) begin
            m_d[j] = m_c[j];
            n_d[j] = n_c[j];
        end
        z_d = m_c[0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0;
            n_q <= '0;
            z_q <= 1'b0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            z_q <= z_d;
        end
    end
    assign M = m_q;
    assign N = n_q;
    assign Z = z_q;
endmodule

// File: tb/tb_red_iterativa.sv
// tb_red_iterativa: scoreboard bench; stimulus queues expected M/N/Z, a monitor checks one edge later
module tb_red_iterativa;
    localparam int K = 4;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [K-1:0] a = '0, b = '0;
    logic [K-1:0] m, n;
    logic         z;
    int           tests = 0, fails = 0;

    typedef struct packed {
        logic [K-1:0] m;
        logic [K-1:0] n;
        logic         z;
        logic [K-1:0] a;
        logic [K-1:0] b;
    } exp_t;
    exp_t q[$];

    red_iterativa #(.K(K)) dut (.clk(clk), .reset(reset), .A(a), .B(b), .M(m), .N(n), .Z(z));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Independent reference: stage i says "A greater" when the upper slice A[K-1:i] exceeds B[K-1:i]
    function automatic exp_t model(input logic [K-1:0] av, input logic [K-1:0] bv);
        exp_t e;
        for (int i = 0; i < K; i++) begin
            e.m[i] = (av >> i) > (bv >> i);
            e.n[i] = (bv >> i) > (av >> i);
        end
        e.z = av > bv;
        e.a = av;
        e.b = bv;
        return e;
    endfunction

    task automatic drive(input logic [K-1:0] av, input logic [K-1:0] bv,
                         input logic [K-1:0] em, input logic [K-1:0] en, input logic ez);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        e.m = em; e.n = en; e.z = ez; e.a = av; e.b = bv;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check($sformatf("M a=%b b=%b", e.a, e.b), m, e.m);
                check($sformatf("N a=%b b=%b", e.a, e.b), n, e.n);
                check($sformatf("Z a=%b b=%b", e.a, e.b), {{(K-1){1'b0}}, z}, {{(K-1){1'b0}}, e.z});
                check("M&N disjoint", m & n, '0);
                check("M run contiguous", m & (m + 1'b1), '0);
                check("N run contiguous", n & (n + 1'b1), '0);
            end
        end
    end

    initial begin
        exp_t e;
        #1;
        check("reset M", m, '0);
        check("reset N", n, '0);
        check("reset Z", {{(K-1){1'b0}}, z}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(4'b1010, 4'b0110, 4'b1111, 4'b0000, 1'b1);
        drive(4'b0101, 4'b0110, 4'b0000, 4'b0011, 1'b0);
        drive(4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
        drive(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        drive(4'b0000, 4'b1000, 4'b0000, 4'b1111, 1'b0);
        drive(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset M", m, '0);
        check("async reset N", n, '0);
        check("async reset Z", {{(K-1){1'b0}}, z}, '0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("held reset M", m, '0);
            check("held reset N", n, '0);
            check("held reset Z", {{(K-1){1'b0}}, z}, '0);
        end
        @(negedge clk);
        reset = 1'b0;
        e.m = 4'b1111; e.n = 4'b0000; e.z = 1'b1; e.a = a; e.b = b;
        q.push_back(e);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                e = model(i[K-1:0], j[K-1:0]);
                drive(e.a, e.b, e.m, e.n, e.z);
            end
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
